// File: rtl/seq_divider.sv
// Iterative signed divider: radix-2 restoring, one quotient bit per clock.
// Quotient truncates toward zero; divide-by-zero and MIN/-1 raise exception.
module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             sign;
  logic             ovf;
  logic             dz;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             neg;

  always_comb begin
    a_mag   = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    b_mag   = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};
    // one extra bit so the borrow of the trial subtract is explicit
    trial   = {rem, quo[WIDTH-1]} - {2'b00, dvs};
    neg     = trial[WIDTH+1];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      rem            <= '0;
      quo            <= '0;
      dvs            <= '0;
      sign           <= 1'b0;
      ovf            <= 1'b0;
      dz             <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_DIV) begin
        quo   <= a_mag;
        dvs   <= b_mag;
        rem   <= '0;
        cnt   <= '0;
        sign  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        ovf   <= (data_operandA == MINV) && (&data_operandB);
        dz    <= (data_operandB == '0);
        state <= (data_operandB == '0) ? DONE : RUN;
      end else begin
        case (state)
          RUN: begin
            if (neg) begin
              rem <= shifted;
              quo <= {quo[WIDTH-2:0], 1'b0};
            end else begin
              rem <= trial[WIDTH:0];
              quo <= {quo[WIDTH-2:0], 1'b1};
            end
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= DONE;
          end
          DONE: begin
            if (dz) data_result <= '0;
            else    data_result <= sign ? -quo : quo;
            data_exception <= dz | ovf;
            data_resultRDY <= 1'b1;
            state          <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Randomized bench for seq_divider against a plain-arithmetic
// reference of signed truncating division.
module tb_seq_divider;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int n_cmp = 0;
  int n_bad = 0;

  seq_divider #(.WIDTH(32), .CNT_W(6)) dut (
    .clock         (clock),
    .reset         (reset),
    .ctrl_DIV      (ctrl_DIV),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .data_result   (data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] q,
                                output logic exc,
                                output int lat);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    lat = 33;
    exc = 1'b0;
    if (b == 32'd0) begin
      q = 32'd0;
      exc = 1'b1;
      lat = 1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      exc = 1'b1;
    end else begin
      q = sa / sb;
    end
  endfunction

  // drive a start; returns with E0 consumed, sitting on a negedge
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    ctrl_DIV = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    @(negedge clock);
    ctrl_DIV = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_rdy(output int n);
    n = 0;
    while (n < 40) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      if (data_resultRDY) break;
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic do_div(input string tag,
                        input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] q;
    logic        exc;
    int          lat;
    int          n;
    model(a, b, q, exc, lat);
    start(a, b);
    wait_rdy(n);
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_q"}, data_result, q);
    chk({tag, "_exc"}, {31'd0, data_exception}, {31'd0, exc});
    @(posedge clock);
    @(negedge clock);
    chk({tag, "_rdylow"}, {31'd0, data_resultRDY}, 32'd0);
    chk({tag, "_hold"}, data_result, q);
  endtask

  initial begin
    int n;
    int seen;
    logic [31:0] a;
    logic [31:0] b;

    reset = 1'b1;
    ctrl_DIV = 1'b1;
    data_operandA = 32'd9;
    data_operandB = 32'd3;
    idle(2);
    ctrl_DIV = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      @(negedge clock);
      chk("rst_q", data_result, 32'd0);
      chk("rst_exc", {31'd0, data_exception}, 32'd0);
      chk("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
    end

    do_div("d100_7", 32'd100, 32'd7);
    do_div("dm7_2", -32'sd7, 32'd2);
    do_div("d7_m2", 32'd7, -32'sd2);
    do_div("dm7_m2", -32'sd7, -32'sd2);
    do_div("d0_5", 32'd0, 32'd5);
    do_div("d5_0", 32'd5, 32'd0);
    do_div("dmin_m1", 32'h8000_0000, 32'hFFFF_FFFF);
    do_div("dmin_1", 32'h8000_0000, 32'd1);
    do_div("dmax_max", 32'h7FFF_FFFF, 32'h7FFF_FFFF);

    // restart mid-flight: only the second op may report
    start(32'd1000, 32'd10);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (data_resultRDY) seen++;
    end
    chk("restart_early_rdy", seen, 0);
    start(32'd81, 32'd9);
    wait_rdy(n);
    chk("restart_lat", n, 33);
    chk("restart_q", data_result, 32'd9);

    // reset mid-flight: no RDY, outputs cleared
    idle(2);
    start(32'd50, 32'd5);
    idle(20);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("midrst_q", data_result, 32'd0);
    chk("midrst_exc", {31'd0, data_exception}, 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (data_resultRDY) seen++;
    end
    chk("midrst_no_rdy", seen, 0);
    do_div("after_rst", 32'd50, 32'd5);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = -$urandom_range(1, 15);
        3: begin a = 32'h8000_0000; b = $urandom_range(0, 1) ? 32'hFFFF_FFFF : $urandom; end
        default: b = $urandom;
      endcase
      do_div($sformatf("rnd%0d", i), a, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
